// File: rtl/post_cov_semipar.sv
// Semi-parallel 2x2 posterior covariance update P_POST = P - K*(H*P).
// Four shared multipliers and two shared wide adders run a fixed six-step schedule.
module post_cov_semipar #(
  parameter int N    = 20,
  parameter int FRAC = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [N-1:0] k00,
  input  logic signed [N-1:0] k01,
  input  logic signed [N-1:0] k10,
  input  logic signed [N-1:0] k11,
  input  logic signed [N-1:0] h00,
  input  logic signed [N-1:0] h01,
  input  logic signed [N-1:0] h10,
  input  logic signed [N-1:0] h11,
  input  logic signed [N-1:0] p00,
  input  logic signed [N-1:0] p01,
  input  logic signed [N-1:0] p10,
  input  logic signed [N-1:0] p11,
  output logic                busy,
  output logic                done,
  output logic                ovf,
  output logic signed [N-1:0] P_POST00,
  output logic signed [N-1:0] P_POST01,
  output logic signed [N-1:0] P_POST10,
  output logic signed [N-1:0] P_POST11
);

  // One guard bit beyond the 2N+1 sum so P_2N - v can never wrap.
  localparam int W = 2 * N + 2;
  localparam logic signed [W-1:0] MAX_W = {{(W-N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_W = {{(W-N+1){1'b1}}, {(N-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  typedef struct packed {
    logic                clip;
    logic signed [N-1:0] val;
  } sat_t;

  state_t state, state_nx;
  logic [2:0] cyc, cyc_nx;
  logic accept;

  logic signed [N-1:0] k00_r, k01_r, k10_r, k11_r;
  logic signed [N-1:0] h00_r, h01_r, h10_r, h11_r;
  logic signed [N-1:0] p00_r, p01_r, p10_r, p11_r;
  logic signed [N-1:0] u00, u01, u10, u11;
  logic signed [N-1:0] t00, t10;
  logic signed [W-1:0] v00, v01, v10, v11;
  logic signed [N-1:0] op_a [4];
  logic signed [N-1:0] op_b [4];
  logic signed [2*N-1:0] prod [4];
  logic signed [W-1:0] add_x0, add_y0, add_x1, add_y1;
  logic signed [W-1:0] sum0, sum1;
  sat_t s0, s1;
  logic ovf_acc;

  function automatic sat_t sat_n(input logic signed [W-1:0] x);
    logic signed [W-1:0] sh;
    sat_t r;
    sh = x >>> FRAC;
    if (sh > MAX_W) begin
      r.clip = 1'b1;
      r.val  = MAX_W[N-1:0];
    end else if (sh < MIN_W) begin
      r.clip = 1'b1;
      r.val  = MIN_W[N-1:0];
    end else begin
      r.clip = 1'b0;
      r.val  = sh[N-1:0];
    end
    return r;
  endfunction

  function automatic logic signed [W-1:0] p2n(input logic signed [N-1:0] p);
    return W'(p) <<< FRAC;
  endfunction

  assign accept = start && (state == IDLE);
  assign busy   = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cyc   <= 3'd0;
    end else begin
      state <= state_nx;
      cyc   <= cyc_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cyc_nx   = cyc;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = RUN;
          cyc_nx   = 3'd1;
        end
      end
      RUN: begin
        if (cyc == 3'd6) begin
          state_nx = IDLE;
          cyc_nx   = 3'd0;
        end else begin
          cyc_nx = cyc + 3'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cyc_nx   = 3'd0;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      prod[i] = op_a[i] * op_b[i];
    end
  end

  // Steps 4 and 6 reuse the adders to subtract V from the up-scaled prior.
  always_comb begin
    add_x0 = W'(prod[0]);
    add_y0 = W'(prod[1]);
    add_x1 = W'(prod[2]);
    add_y1 = W'(prod[3]);
    if (cyc == 3'd4) begin
      add_x0 = p2n(p00_r);
      add_y0 = -v00;
      add_x1 = p2n(p10_r);
      add_y1 = -v10;
    end else if (cyc == 3'd6) begin
      add_x0 = p2n(p01_r);
      add_y0 = -v01;
      add_x1 = p2n(p11_r);
      add_y1 = -v11;
    end
    sum0 = add_x0 + add_y0;
    sum1 = add_x1 + add_y1;
  end

  assign s0 = sat_n(sum0);
  assign s1 = sat_n(sum1);

  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= 1'b0;
      ovf      <= 1'b0;
      ovf_acc  <= 1'b0;
      P_POST00 <= '0;
      P_POST01 <= '0;
      P_POST10 <= '0;
      P_POST11 <= '0;
      k00_r <= '0; k01_r <= '0; k10_r <= '0; k11_r <= '0;
      h00_r <= '0; h01_r <= '0; h10_r <= '0; h11_r <= '0;
      p00_r <= '0; p01_r <= '0; p10_r <= '0; p11_r <= '0;
      u00 <= '0; u01 <= '0; u10 <= '0; u11 <= '0;
      v00 <= '0; v01 <= '0; v10 <= '0; v11 <= '0;
      t00 <= '0; t10 <= '0;
      for (int i = 0; i < 4; i++) begin
        op_a[i] <= '0;
        op_b[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (accept) begin
        k00_r <= k00; k01_r <= k01; k10_r <= k10; k11_r <= k11;
        h00_r <= h00; h01_r <= h01; h10_r <= h10; h11_r <= h11;
        p00_r <= p00; p01_r <= p01; p10_r <= p10; p11_r <= p11;
        ovf     <= 1'b0;
        ovf_acc <= 1'b0;
        op_a[0] <= h00; op_a[1] <= h01; op_a[2] <= h10; op_a[3] <= h11;
        op_b[0] <= p00; op_b[1] <= p10; op_b[2] <= p00; op_b[3] <= p10;
      end else if (state == RUN) begin
        case (cyc)
          3'd1: begin
            u00     <= s0.val;
            u10     <= s1.val;
            ovf_acc <= ovf_acc | s0.clip | s1.clip;
            op_a[0] <= h00_r; op_a[1] <= h01_r; op_a[2] <= h10_r; op_a[3] <= h11_r;
            op_b[0] <= p01_r; op_b[1] <= p11_r; op_b[2] <= p01_r; op_b[3] <= p11_r;
          end
          3'd2: begin
            u01     <= s0.val;
            u11     <= s1.val;
            ovf_acc <= ovf_acc | s0.clip | s1.clip;
            op_a[0] <= k00_r; op_a[1] <= k01_r; op_a[2] <= k10_r; op_a[3] <= k11_r;
            op_b[0] <= u00;   op_b[1] <= u10;   op_b[2] <= u00;   op_b[3] <= u10;
          end
          3'd3: begin
            v00     <= sum0;
            v10     <= sum1;
            op_b[0] <= u01; op_b[1] <= u11; op_b[2] <= u01; op_b[3] <= u11;
          end
          3'd4: begin
            t00     <= s0.val;
            t10     <= s1.val;
            ovf_acc <= ovf_acc | s0.clip | s1.clip;
          end
          3'd5: begin
            v01 <= sum0;
            v11 <= sum1;
          end
          3'd6: begin
            P_POST00 <= t00;
            P_POST10 <= t10;
            P_POST01 <= s0.val;
            P_POST11 <= s1.val;
            ovf      <= ovf_acc | s0.clip | s1.clip;
            ovf_acc  <= ovf_acc | s0.clip | s1.clip;
            done     <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_post_cov_semipar.sv
// Directed bench for post_cov_semipar: vector table of hand-computed results
// plus hand-written handshake, back-to-back and mid-run reset sequences.
module tb_post_cov_semipar;

  typedef struct {
    logic [3:0][19:0] k;
    logic [3:0][19:0] h;
    logic [3:0][19:0] p;
    logic [3:0][19:0] e;
    logic             eovf;
  } vec_t;

  logic clk;
  logic rst;
  logic start;
  logic signed [19:0] k00, k01, k10, k11;
  logic signed [19:0] h00, h01, h10, h11;
  logic signed [19:0] p00, p01, p10, p11;
  logic busy, done, ovf;
  logic signed [19:0] P_POST00, P_POST01, P_POST10, P_POST11;

  int checkCount = 0;
  int passCount  = 0;
  vec_t vecs [5];

  post_cov_semipar #(.N(20), .FRAC(10)) dut (
    .clk(clk), .rst(rst), .start(start),
    .k00(k00), .k01(k01), .k10(k10), .k11(k11),
    .h00(h00), .h01(h01), .h10(h10), .h11(h11),
    .p00(p00), .p01(p01), .p10(p10), .p11(p11),
    .busy(busy), .done(done), .ovf(ovf),
    .P_POST00(P_POST00), .P_POST01(P_POST01),
    .P_POST10(P_POST10), .P_POST11(P_POST11)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(
    input int k0, input int k1, input int k2, input int k3,
    input int h0, input int h1, input int h2, input int h3,
    input int q0, input int q1, input int q2, input int q3,
    input int e0, input int e1, input int e2, input int e3,
    input int eo);
    vec_t v;
    v.k[0] = 20'(k0); v.k[1] = 20'(k1); v.k[2] = 20'(k2); v.k[3] = 20'(k3);
    v.h[0] = 20'(h0); v.h[1] = 20'(h1); v.h[2] = 20'(h2); v.h[3] = 20'(h3);
    v.p[0] = 20'(q0); v.p[1] = 20'(q1); v.p[2] = 20'(q2); v.p[3] = 20'(q3);
    v.e[0] = 20'(e0); v.e[1] = 20'(e1); v.e[2] = 20'(e2); v.e[3] = 20'(e3);
    v.eovf = (eo != 0);
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic driveInputs(input vec_t v);
    k00 = v.k[0]; k01 = v.k[1]; k10 = v.k[2]; k11 = v.k[3];
    h00 = v.h[0]; h01 = v.h[1]; h10 = v.h[2]; h11 = v.h[3];
    p00 = v.p[0]; p01 = v.p[1]; p10 = v.p[2]; p11 = v.p[3];
  endtask

  task automatic checkResult(input vec_t v, input string tag);
    checkOutput({tag, " P_POST00"}, P_POST00, $signed(v.e[0]));
    checkOutput({tag, " P_POST01"}, P_POST01, $signed(v.e[1]));
    checkOutput({tag, " P_POST10"}, P_POST10, $signed(v.e[2]));
    checkOutput({tag, " P_POST11"}, P_POST11, $signed(v.e[3]));
    checkOutput({tag, " ovf"}, ovf, v.eovf);
  endtask

  // One full run: accept, count cycles to done, then verify results and pulse width.
  task automatic applyStimulus(input vec_t v, input string tag);
    int cyc;
    bit busyBad;
    @(posedge clk); #1;
    driveInputs(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    busyBad = 1'b0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy !== 1'b1) busyBad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput({tag, " latency"}, cyc, 7);
    checkOutput({tag, " busy_during_run"}, busyBad, 0);
    checkOutput({tag, " busy_at_done"}, busy, 0);
    checkResult(v, tag);
    @(posedge clk); #1;
    checkOutput({tag, " done_width"}, done, 0);
  endtask

  initial begin
    bit sawDone;
    string names [5];

    vecs[0] = mkVec(0, 0, 0, 0,  1024, 0, 0, 1024,  2048, 512, 512, 1024,
                    2048, 512, 512, 1024, 0);
    vecs[1] = mkVec(512, 0, 0, 512,  1024, 0, 0, 1024,  2048, 512, 512, 1024,
                    1024, 256, 256, 512, 0);
    vecs[2] = mkVec(512, 0, 256, 0,  1024, 0, 0, 0,  1024, 0, 0, 1024,
                    512, 0, -256, 1024, 0);
    vecs[3] = mkVec(-1024, 0, 0, -1024,  1024, 0, 0, 1024,  524287, 0, 0, 1024,
                    524287, 0, 0, 2048, 1);
    vecs[4] = vecs[0];
    names[0] = "identity";
    names[1] = "half_gain";
    names[2] = "single_row";
    names[3] = "saturation";
    names[4] = "clean_after_sat";

    rst = 1'b1;
    start = 1'b0;
    driveInputs(mkVec(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0, 0));
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset ovf", ovf, 0);
    checkOutput("reset P_POST00", P_POST00, 0);
    checkOutput("reset P_POST11", P_POST11, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], names[i]);

    // Stray starts mid-run and input changes after accept must not matter.
    @(posedge clk); #1;
    driveInputs(vecs[1]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    driveInputs(vecs[3]);
    for (int c = 2; c <= 7; c++) begin
      @(posedge clk); #1;
      start = (c == 2 || c == 5);
    end
    checkOutput("ignore done_at_7", done, 1);
    checkResult(vecs[1], "ignore");
    @(posedge clk); #1;
    checkOutput("ignore no_reaccept", busy, 0);

    // Start held high: back-to-back runs, results stable between done pulses.
    @(posedge clk); #1;
    driveInputs(vecs[0]);
    start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("hold done1", done, 1);
    checkResult(vecs[0], "hold_run1");
    driveInputs(vecs[1]);
    for (int c = 8; c <= 13; c++) begin
      @(posedge clk); #1;
      checkOutput("hold busy", busy, 1);
      checkOutput("hold done_low", done, 0);
      checkOutput("hold P_POST00 stable", P_POST00, 2048);
      checkOutput("hold P_POST11 stable", P_POST11, 1024);
    end
    @(posedge clk); #1;
    checkOutput("hold done2", done, 1);
    checkResult(vecs[1], "hold_run2");
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("hold idle_after", busy, 0);

    // Mid-run reset after a saturating run so the cleared values are visible.
    applyStimulus(vecs[3], "sat_before_reset");
    @(posedge clk); #1;
    driveInputs(vecs[2]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset done", done, 0);
    checkOutput("midreset ovf", ovf, 0);
    checkOutput("midreset P_POST00", P_POST00, 0);
    checkOutput("midreset P_POST01", P_POST01, 0);
    checkOutput("midreset P_POST10", P_POST10, 0);
    checkOutput("midreset P_POST11", P_POST11, 0);
    sawDone = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("midreset no_done", sawDone, 0);
    applyStimulus(vecs[2], "after_reset");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/post_cov_semipar.md
# post_cov_semipar

Semi-parallel 2x2 posterior covariance update for the Kalman correction step: P_POST = P − K·(H·P), where P is the prior covariance, K the Kalman gain and H the measurement matrix. It consumes the prior covariance produced by the predict step. Its results feed the next predict iteration.
- Resources: 4 fixed-point multipliers with full 2N products and 2 reusable 2N-domain adders.
- Schedule: fixed 8 cycles.
- Outputs: saturated, FRAC-aligned N-bit values.

## Interface
- N, 20, data word width (signed two's complement).
- FRAC, 10, fractional bits; 1.0 = 2^FRAC.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- k00 k01 k10 k11  in  N each  gain K; sampled on the accept edge.
- h00 h01 h10 h11  in  N each  measurement matrix H; sampled on the accept edge.
- p00 p01 p10 p11  in  N each  prior covariance P; sampled on the accept edge.
- busy  out  1  high from accept edge until the done edge.
- done  out  1  one-cycle pulse; outputs are valid when it is high.
- ovf  out  1  at least one saturation occurred in the last run; cleared on accept.
- P_POST00 P_POST01 P_POST10 P_POST11  out  N each  result; held until the next done.

## Operation
- Reset (rst=1 at an edge) clears:
  - busy, done, ovf, cyc and all P_POST* to 0;
  - all internal operand, U, V and temp registers to 0.
- Reset mid-run aborts the run; no done pulse is produced.
- Accept: on a start=1 edge with busy=0, latch all 12 inputs into internal registers. Then busy←1, cyc←1, ovf←0, and the multiplier operands are loaded for stage 1.
- start=1 while busy=1 is ignored. Input changes after the accept edge do not affect the run.
- States: IDLE (busy=0) → RUN with cyc=1..6 → IDLE. done is registered at the cyc=6 edge.
- Per-edge schedule (latched operands; mul products are combinational):
  - cyc1: U col0 = H·[p00;p10]; u00, u10 ← satN(sum); load U col1 operands.
  - cyc2: U col1 = H·[p01;p11]; u01, u11 ← satN(sum); load K·[u00;u10].
  - cyc3: v00_2N, v10_2N ← 2N sums; load K·[u01;u11].
  - cyc4: post col0 temps ← satN(P_2N − v), rows 0 and 1.
  - cyc5: v01_2N, v11_2N ← 2N sums.
  - cyc6: col1 ← satN(P_2N − v). All four P_POST* load together; done←1, busy←0.
- Arithmetic:
  - Products are 2N wide.
  - Adder results are 2N+1 wide and are never wrapped before satN.
  - P_2N = sign-extend(p) <<< FRAC.
  - satN(x) = floor(x / 2^FRAC), clamped to [−2^(N−1), 2^(N−1)−1]. The floor is an arithmetic shift (truncation toward −∞).
  - Any clamp in any satN, including the u terms, sets ovf; ovf is sticky until the next accept. ovf updates with P_POST* at the done edge.
- P_POST* never change mid-run; previous results stay visible until the new done.

## Timing
- start high in cycle 0 (accept edge) → done=1 in cycle 7. Total 8 cycles; latency is constant.
- busy=1 in cycles 1–6 and 0 in cycle 7.
- A start in the done cycle (cycle 7) is accepted. With start held high, runs repeat back-to-back, with done every 7 cycles after the first.
- done width is exactly 1 cycle.
- Reset dominates start on the same edge.

## Test plan
(N=20, FRAC=10, 1.0=1024)
- Identity pass-through: H=I, K=0, P=[2048,512;512,1024]. Expect P_POST=P, done exactly in cycle 7, ovf=0, busy high cycles 1–6.
- Half-gain: H=I, K=diag(512,512), same P. Expect P_POST=[1024,256;256,512].
- Single-row measurement: H=[1024,0;0,0], K=[512,0;256,0], P=diag(1024,1024). Expect U=[1024,0;0,0], V=[512,0;256,0], P_POST=[512,0;−256,1024].
- Saturation: H=I, K=diag(−1024,−1024), P=diag(524287,1024). Expect P_POST00=524287 (clamped), P_POST11=2048, off-diagonals 0, ovf=1. The next clean run returns ovf=0.
- Handshake:
  - start pulsed in cycles 2 and 5 of a run, with all inputs changed after the accept edge: ignored; result matches the latched inputs.
  - start held high: accepted again in each done cycle; P_POST* unchanged between done pulses.
- Reset mid-run: assert rst in cycle 3. Expect busy/done/ovf/P_POST*=0 the next cycle and no done pulse. A new start then yields the correct result 7 cycles later.
